// File: rtl/comma_align_ctrl.sv
// K28.5 word-alignment controller: finds the comma bit offset in the raw 10-bit stream,
// locks after repeated same-offset commas, and emits boundary-corrected words one cycle later.
module comma_align_ctrl #(
   parameter int DATA_WIDTH    = 10,
   parameter int LOCK_CNT      = 3,
   parameter int LOSS_CNT      = 4,
   parameter int CHECK_TIMEOUT = 255
) (
   input  logic                  CLK,
   input  logic                  Rst,
   input  logic [DATA_WIDTH-1:0] Data_in,
   input  logic                  Data_valid,
   output logic [DATA_WIDTH-1:0] Data_out,
   output logic                  Data_out_valid,
   output logic                  Comma_det,
   output logic                  Locked,
   output logic [3:0]            Align_offset
);

   localparam logic [DATA_WIDTH-1:0] K28_5_RDN = 10'h17C;
   localparam logic [DATA_WIDTH-1:0] K28_5_RDP = 10'h283;

   localparam int CNT_W  = $clog2(LOCK_CNT + 1);
   localparam int MISS_W = $clog2(LOSS_CNT + 1);
   localparam int IDLE_W = $clog2(CHECK_TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_CNT - 1);
   localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(LOSS_CNT);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(CHECK_TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(CHECK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_CHECK,
      ST_ALIGNED
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   prev_q, prev_d;
   logic                    prev_ok_q, prev_ok_d;
   logic [3:0]              offset_q, offset_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [MISS_W-1:0]       miss_q, miss_d;
   logic [IDLE_W-1:0]       idle_q, idle_d;
   logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
   logic                    out_valid_q, out_valid_d;
   logic                    comma_det_q, comma_det_d;
   logic                    locked_q, locked_d;

   logic [2*DATA_WIDTH-1:0] window;
   logic [9:0]              comma_hit;
   logic                    hit;
   logic [3:0]              hit_off;

   // Bit 0 of the window is the oldest received bit.
   assign window = {Data_in, prev_q};
   assign hit    = |comma_hit;

   // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
   always_comb begin
      comma_hit = '0;
      hit_off   = '0;
      for (int o = 0; o < 10; o++) begin
         comma_hit[o] = prev_ok_q &&
                        ((window[o +: 10] == K28_5_RDN) || (window[o +: 10] == K28_5_RDP));
      end
      // Descending scan: the last assignment, i.e. the lowest matching offset, wins.
      for (int o = 9; o >= 0; o--) begin
         if (comma_hit[o]) hit_off = 4'(o);
      end
   end

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      prev_ok_d = prev_ok_q;
      offset_d  = offset_q;
      cnt_d     = cnt_q;
      miss_d    = miss_q;
      idle_d    = idle_q;

      if (Data_valid) begin
         prev_d    = Data_in;
         prev_ok_d = 1'b1;
         unique case (state_q)
            ST_SEARCH: begin
               if (hit) begin
                  offset_d = hit_off;
                  cnt_d    = CNT_W'(1);
                  idle_d   = '0;
                  miss_d   = '0;
                  state_d  = (LOCK_CNT == 1) ? ST_ALIGNED : ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (hit && (hit_off == offset_q)) begin
                  idle_d = '0;
                  if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q >= CNT_LAST) begin
                     state_d = ST_ALIGNED;
                     miss_d  = '0;
                  end
               end else if (hit) begin
                  offset_d = hit_off;
                  cnt_d    = CNT_W'(1);
                  idle_d   = '0;
               end else begin
                  if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
                  if (idle_q >= IDLE_LAST) state_d = ST_SEARCH;
               end
            end
            ST_ALIGNED: begin
               // Any comma at the locked offset clears misses, even if a lower offset also matched.
               if (comma_hit[offset_q]) begin
                  miss_d = '0;
               end else if (hit) begin
                  if (miss_q != MISS_MAX) miss_d = miss_q + MISS_W'(1);
                  if (miss_q >= MISS_LAST) state_d = ST_SEARCH;
               end
            end
            default: state_d = ST_SEARCH;
         endcase
      end
   end

   // The slice uses the updated offset, so a relatching comma leaves already aligned.
   always_comb begin
      data_out_d  = data_out_q;
      comma_det_d = 1'b0;
      out_valid_d = Data_valid;
      if (Data_valid) begin
         data_out_d  = DATA_WIDTH'(window >> offset_d);
         comma_det_d = (data_out_d == K28_5_RDN) || (data_out_d == K28_5_RDP);
      end
   end

   assign locked_d = (state_d == ST_ALIGNED);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (Rst) begin
         state_q     <= ST_SEARCH;
         prev_q      <= '0;
         prev_ok_q   <= 1'b0;
         offset_q    <= '0;
         cnt_q       <= '0;
         miss_q      <= '0;
         idle_q      <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         comma_det_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         prev_ok_q   <= prev_ok_d;
         offset_q    <= offset_d;
         cnt_q       <= cnt_d;
         miss_q      <= miss_d;
         idle_q      <= idle_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         comma_det_q <= comma_det_d;
         locked_q    <= locked_d;
      end
   end

   assign Data_out       = data_out_q;
   assign Data_out_valid = out_valid_q;
   assign Comma_det      = comma_det_q;
   assign Locked         = locked_q;
   assign Align_offset   = offset_q;

endmodule
